shift_add_mult: RTL and testbench

SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

---
 rtl/shift_add_mult_pkg.sv | 14 +
 rtl/shift_add_mult_control.sv | 69 ++++++
 rtl/shift_add_mult.sv | 87 ++++++++
 tb/tb_shift_add_mult.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_add_mult_pkg.sv
// Shared types and constants for the shift-and-add multiplier.
package shift_add_mult_pkg;

  // Default operand width in bits.
  localparam int unsigned DEFAULT_N = 4;

  // Control FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : shift_add_mult_pkg

// File: rtl/shift_add_mult_control.sv
// Control for the shift-and-add multiplier: sequencing FSM and bit counter.
// Drives load/shift strobes into the datapath, plus the busy/done status.
module mult_control
  import shift_add_mult_pkg::*;
#(
  parameter int unsigned N = DEFAULT_N
) (
  input  logic   clk,
  input  logic   rst,      // asynchronous, active-low
  input  logic   start_i,
  input  logic   zero_i,   // an operand is zero at the start edge
  output logic   load_o,
  output logic   shift_o,
  output logic   busy_o,
  output logic   done_o,
  output state_e state_o   // debug view of the FSM state
);

  localparam int unsigned CW = $clog2(N + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // State and counter registers; reset aborts any operation in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter and strobe decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_o  = 1'b0;
    shift_o = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          load_o = 1'b1;
          if (zero_i) begin
            // Zero operand: the product is known, skip the iteration.
            state_d = ST_DONE;
          end else begin
            state_d = ST_CALC;
            cnt_d   = CW'(N);
          end
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        shift_o = 1'b1;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_o  = (state_q == ST_CALC);
  assign done_o  = (state_q == ST_DONE);
  assign state_o = state_q;

endmodule : mult_control

// File: rtl/shift_add_mult.sv
// Sequential shift-and-add unsigned multiplier, one multiplier bit per cycle.
//
// Handshake: start is sampled on each rising edge while busy=0 (IDLE or
// DONE); an accepting edge captures a and b. busy stays high for the N
// iteration cycles, then done pulses for exactly one cycle with p valid.
// start is ignored while busy=1; p holds its value until the next accepted
// start. Asserting start during the done cycle chains the next operation
// with no idle gap.
module shift_add_mult
  import shift_add_mult_pkg::*;
#(
  parameter int unsigned N = DEFAULT_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] p
);

  logic [N-1:0] ma_q, ma_d;   // multiplicand
  logic [N-1:0] hi_q, hi_d;   // accumulator (upper product half)
  logic [N-1:0] mb_q, mb_d;   // multiplier, shifted out as product low half fills
  logic [N:0]   sum;
  logic         zero;
  logic         load;
  logic         shift;
  state_e       ctrl_state;

  assign zero = (a == '0) || (b == '0);

  mult_control #(.N(N)) u_ctrl (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .zero_i  (zero),
    .load_o  (load),
    .shift_o (shift),
    .busy_o  (busy),
    .done_o  (done),
    .state_o (ctrl_state)
  );

  // Conditional add of the multiplicand, with one carry bit of headroom.
  always_comb begin
    sum = {1'b0, hi_q} + (mb_q[0] ? {1'b0, ma_q} : '0);
  end

  // Datapath next-state: load (clearing mb on a zero operand so p reads 0)
  // or shift {carry, hi, mb} right by one.
  always_comb begin
    ma_d = ma_q;
    hi_d = hi_q;
    mb_d = mb_q;
    if (load) begin
      ma_d = a;
      hi_d = '0;
      mb_d = zero ? '0 : b;
    end else if (shift) begin
      hi_d = sum[N:1];
      mb_d = {sum[0], mb_q[N-1:1]};
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ma_q <= '0;
      hi_q <= '0;
      mb_q <= '0;
    end else begin
      ma_q <= ma_d;
      hi_q <= hi_d;
      mb_q <= mb_d;
    end
  end

  assign p = {hi_q, mb_q};

  // busy must mirror the CALC state exactly.
  a_busy_is_calc : assert property (@(posedge clk) disable iff (!rst)
    busy == (ctrl_state == ST_CALC));

endmodule : shift_add_mult

// File: tb/tb_shift_add_mult.sv
// Directed bench for shift_add_mult with N=4.
module tb_shift_add_mult;

  localparam int N = 4;

  logic           clk;
  logic           rst;
  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*N-1:0] p;

  int pass_cnt  = 0;
  int total_cnt = 0;

  shift_add_mult #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset drives everything to zero; idle stays idle without start.
  task automatic test_reset;
    rst = 1'b0; start = 1'b0; a = '0; b = '0;
    @(negedge clk); @(negedge clk);
    total_cnt++;
    if ({busy, done, p} !== 10'd0)
      $display("FAIL reset_outputs: busy/done/p=%b/%b/%0d expected 0/0/0", busy, done, p);
    else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({busy, done, p} !== 10'd0)
      $display("FAIL reset_idle: busy/done/p=%b/%b/%0d expected 0/0/0", busy, done, p);
    else pass_cnt++;
  endtask

  // 13*11: busy 4 cycles, done on the 5th, p=143, held afterwards.
  task automatic test_basic;
    start = 1'b1; a = 4'd13; b = 4'd11;
    @(negedge clk);
    start = 1'b0; a = 4'd5; b = 4'd5;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if ({busy, done} !== 2'b10)
        $display("FAIL basic_calc_c%0d: busy/done=%b expected 10", i, {busy, done});
      else pass_cnt++;
      @(negedge clk);
    end
    total_cnt++;
    if ({busy, done} !== 2'b01 || p !== 8'd143)
      $display("FAIL basic_done: busy/done=%b p=%0d expected 01 p=143", {busy, done}, p);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({busy, done} !== 2'b00 || p !== 8'd143)
      $display("FAIL basic_hold: busy/done=%b p=%0d expected 00 p=143", {busy, done}, p);
    else pass_cnt++;
  endtask

  // 15*15 exercises the adder carry: p=225.
  task automatic test_carry;
    start = 1'b1; a = 4'd15; b = 4'd15;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if ({busy, done} !== 2'b10)
        $display("FAIL carry_calc_c%0d: busy/done=%b expected 10", i, {busy, done});
      else pass_cnt++;
      @(negedge clk);
    end
    total_cnt++;
    if (done !== 1'b1 || p !== 8'd225)
      $display("FAIL carry_done: done=%b p=%0d expected 1 p=225", done, p);
    else pass_cnt++;
    @(negedge clk);
  endtask

  // Zero operands go straight to DONE with p=0, busy never set.
  task automatic test_zero;
    start = 1'b1; a = 4'd0; b = 4'd9;
    @(negedge clk);
    start = 1'b0;
    total_cnt++;
    if ({busy, done} !== 2'b01 || p !== 8'd0)
      $display("FAIL zero_a_done: busy/done=%b p=%0d expected 01 p=0", {busy, done}, p);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({busy, done} !== 2'b00 || p !== 8'd0)
      $display("FAIL zero_a_after: busy/done=%b p=%0d expected 00 p=0", {busy, done}, p);
    else pass_cnt++;
    start = 1'b1; a = 4'd7; b = 4'd0;
    @(negedge clk);
    start = 1'b0;
    total_cnt++;
    if ({busy, done} !== 2'b01 || p !== 8'd0)
      $display("FAIL zero_b_done: busy/done=%b p=%0d expected 01 p=0", {busy, done}, p);
    else pass_cnt++;
    @(negedge clk);
  endtask

  // 6*7 with start held high: one result, then a new op from DONE with 2*5.
  task automatic test_start_held;
    start = 1'b1; a = 4'd6; b = 4'd7;
    @(negedge clk);
    a = 4'd1; b = 4'd1;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if ({busy, done} !== 2'b10)
        $display("FAIL held_calc_c%0d: busy/done=%b expected 10", i, {busy, done});
      else pass_cnt++;
      @(negedge clk);
    end
    total_cnt++;
    if ({busy, done} !== 2'b01 || p !== 8'd42)
      $display("FAIL held_done1: busy/done=%b p=%0d expected 01 p=42", {busy, done}, p);
    else pass_cnt++;
    a = 4'd2; b = 4'd5;
    @(negedge clk);
    a = 4'd0; b = 4'd0;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if ({busy, done} !== 2'b10)
        $display("FAIL held_calc2_c%0d: busy/done=%b expected 10", i, {busy, done});
      else pass_cnt++;
      @(negedge clk);
    end
    total_cnt++;
    if ({busy, done} !== 2'b01 || p !== 8'd10)
      $display("FAIL held_done2: busy/done=%b p=%0d expected 01 p=10", {busy, done}, p);
    else pass_cnt++;
    start = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({busy, done} !== 2'b00 || p !== 8'd10)
      $display("FAIL held_idle: busy/done=%b p=%0d expected 00 p=10", {busy, done}, p);
    else pass_cnt++;
  endtask

  // Reset in the 2nd CALC cycle of 9*5 clears outputs at once, no done.
  task automatic test_abort;
    start = 1'b1; a = 4'd9; b = 4'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b1)
      $display("FAIL abort_calc2: busy=%b expected 1", busy);
    else pass_cnt++;
    #2 rst = 1'b0;
    #1;
    total_cnt++;
    if ({busy, done, p} !== 10'd0)
      $display("FAIL abort_async: busy/done/p=%b/%b/%0d expected 0/0/0", busy, done, p);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if ({busy, done, p} !== 10'd0)
        $display("FAIL abort_quiet_c%0d: busy/done/p=%b/%b/%0d expected 0/0/0", i, busy, done, p);
      else pass_cnt++;
      @(negedge clk);
    end
    start = 1'b1; a = 4'd9; b = 4'd5;
    @(negedge clk);
    start = 1'b0;
    total_cnt++;
    if (busy !== 1'b1)
      $display("FAIL abort_rerun_busy: busy=%b expected 1", busy);
    else pass_cnt++;
    repeat (4) @(negedge clk);
    total_cnt++;
    if (done !== 1'b1 || p !== 8'd45)
      $display("FAIL abort_rerun_done: done=%b p=%0d expected 1 p=45", done, p);
    else pass_cnt++;
    @(negedge clk);
  endtask

  // 2*2 then 3*4 chained from the DONE cycle with no idle gap.
  task automatic test_back_to_back;
    start = 1'b1; a = 4'd2; b = 4'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    total_cnt++;
    if ({busy, done} !== 2'b01 || p !== 8'd4)
      $display("FAIL b2b_done1: busy/done=%b p=%0d expected 01 p=4", {busy, done}, p);
    else pass_cnt++;
    start = 1'b1; a = 4'd3; b = 4'd4;
    @(negedge clk);
    start = 1'b0;
    total_cnt++;
    if ({busy, done} !== 2'b10)
      $display("FAIL b2b_no_gap: busy/done=%b expected 10", {busy, done});
    else pass_cnt++;
    repeat (4) @(negedge clk);
    total_cnt++;
    if ({busy, done} !== 2'b01 || p !== 8'd12)
      $display("FAIL b2b_done2: busy/done=%b p=%0d expected 01 p=12", {busy, done}, p);
    else pass_cnt++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_zero();
    test_start_held();
    test_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_shift_add_mult
